// File: rtl/tiny16_pkg.sv
// Shared types and constants for the tiny16 CPU output UART: transmitter states,
// ASCII codes used by the hex formatter, and 8N1 frame constants.
package tiny16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_NEXT
  } tx_state_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  localparam logic FRAME_START     = 1'b0;
  localparam logic FRAME_STOP      = 1'b1;
  localparam int   FRAME_DATA_BITS = 8;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? ASCII_ZERO + {4'd0, nib}
                         : ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. The final stop-bit cycle is either IDLE or NEXT,
// so a following byte (or word) starts with no idle gap on the line.
module uart_tx_byte
  import tiny16_pkg::*;
#(
  parameter int CLK_DIV = 139
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_more,
  output logic       o_tx,
  output logic       o_idle,
  output logic       o_done
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  STOP_LAST = CW'(CLK_DIV - 2);
  localparam logic [2:0]     BIT_LAST  = 3'(FRAME_DATA_BITS - 1);

  tx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tx_nxt    = FRAME_STOP;
    o_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (i_load) begin
          w_state_nxt = ST_START;
          w_byte_nxt  = i_byte;
        end
      end
      ST_START: begin
        if (w_baud_end) w_state_nxt = ST_BITS;
      end
      ST_BITS: begin
        if (w_baud_end) begin
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == BIT_LAST) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Stop bit's last cycle is spent in NEXT (load) or IDLE (accept).
        if (r_baud == STOP_LAST) begin
          o_done = 1'b1;
          if (i_more) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_state_nxt = ST_IDLE;
            w_baud_nxt  = '0;
          end
        end
      end
      ST_NEXT: begin
        w_state_nxt = ST_START;
        w_byte_nxt  = i_byte;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_START: w_tx_nxt = FRAME_START;
      ST_BITS:  w_tx_nxt = w_byte_nxt[w_bit_nxt];
      default:  w_tx_nxt = FRAME_STOP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= FRAME_STOP;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign o_tx   = r_tx;
  assign o_idle = (r_state == ST_IDLE);

endmodule

// File: rtl/out_uart_tx.sv
// CPU OUT-port UART transmitter: sends each accepted 16-bit word as two raw bytes,
// or, with OUT_TX_HEX_EN defined, as four uppercase hex digits followed by CR LF.
module out_uart_tx
  import tiny16_pkg::*;
#(
  parameter int CLK_DIV = 139
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic        VALID,
  output logic        READY,
  output logic        TX,
  output logic        BUSY
);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("out_uart_tx: CLK_DIV must be at least 2");
    end
  endgenerate

`ifdef OUT_TX_HEX_EN
  localparam logic [2:0] LAST_IDX = 3'd5;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    return hex_ascii(word[15:12]);
      3'd1:    return hex_ascii(word[11:8]);
      3'd2:    return hex_ascii(word[7:4]);
      3'd3:    return hex_ascii(word[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction
`else
  localparam logic [2:0] LAST_IDX = 3'd1;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic [2:0] idx);
    return (idx == 3'd0) ? word[15:8] : word[7:0];
  endfunction
`endif

  logic        r_alive;
  logic [15:0] r_word;
  logic [2:0]  r_idx;
  logic        w_idle, w_done, w_more, w_accept;
  logic [7:0]  w_byte;

  assign READY    = r_alive & w_idle;
  assign BUSY     = r_alive & ~w_idle;
  assign w_accept = READY & VALID;
  assign w_more   = (r_idx != LAST_IDX);
  // The first byte comes straight from DATA because the word is captured on the same edge.
  assign w_byte   = w_idle ? pick_byte(DATA, 3'd0) : pick_byte(r_word, r_idx);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_alive <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_word <= DATA;
        r_idx  <= '0;
      end else if (w_done && w_more) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_byte (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_accept),
    .i_byte  (w_byte),
    .i_more  (w_more),
    .o_tx    (TX),
    .o_idle  (w_idle),
    .o_done  (w_done)
  );

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: two instances (CLK_DIV=4 and CLK_DIV=2), line traces decoded
// by a behavioural UART receiver and compared against a frame-level model.
module tb_out_uart_tx;

  localparam int DIV0 = 4;
  localparam int DIV1 = 2;
  localparam int LOGN = 8192;
`ifdef OUT_TX_HEX_EN
  localparam int NB = 6;
`else
  localparam int NB = 2;
`endif

  typedef logic [7:0] bq_t[$];
  typedef logic       lq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_d [2];
  logic        valid_d[2];
  logic        ready_w[2];
  logic        tx_w   [2];
  logic        busy_w [2];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic tx_log  [2][LOGN];
  logic rdy_log [2][LOGN];
  logic busy_log[2][LOGN];

  out_uart_tx #(.CLK_DIV(DIV0)) u_dut0 (
    .CLK(clk), .RST(rst_n), .DATA(data_d[0]), .VALID(valid_d[0]),
    .READY(ready_w[0]), .TX(tx_w[0]), .BUSY(busy_w[0])
  );

  out_uart_tx #(.CLK_DIV(DIV1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .DATA(data_d[1]), .VALID(valid_d[1]),
    .READY(ready_w[1]), .TX(tx_w[1]), .BUSY(busy_w[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Entry [cyc] holds what each output showed during the cycle after edge number cyc.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      for (int d = 0; d < 2; d++) begin
        tx_log[d][cyc]   = tx_w[d];
        rdy_log[d][cyc]  = ready_w[d];
        busy_log[d][cyc] = busy_w[d];
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int word_cycles(input int d);
    return NB * 10 * div_of(d);
  endfunction

  function automatic bq_t word_bytes(input logic [15:0] w);
    bq_t q;
`ifdef OUT_TX_HEX_EN
    for (int i = 0; i < 4; i++) begin
      int n;
      n = (int'(w) >> (12 - 4 * i)) & 15;
      q.push_back((n < 10) ? 8'(48 + n) : 8'(65 + n - 10));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`else
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
`endif
    return q;
  endfunction

  function automatic lq_t line_wave(input bq_t bytes, input int div);
    lq_t q;
    foreach (bytes[i]) begin
      repeat (div) q.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (div) q.push_back(bytes[i][b]);
      repeat (div) q.push_back(1'b1);
    end
    return q;
  endfunction

  function automatic lq_t slice(input int d, input int from, input int len);
    lq_t q;
    for (int k = 0; k < len; k++)
      if (from + k >= 0 && from + k < LOGN) q.push_back(tx_log[d][from + k]);
    return q;
  endfunction

  function automatic int count_diff(input lq_t a, input lq_t b);
    int n;
    n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] !== b[i]) n++;
    return n;
  endfunction

  // Receiver: every bit slot must hold one value for exactly div samples.
  function automatic int decode(input lq_t q, input int div, output bq_t bytes);
    int errs;
    int i;
    errs = 0;
    i = 0;
    bytes = {};
    while (i < q.size()) begin
      if (q[i] === 1'b0) begin
        logic [9:0] slots;
        if (i + 10 * div > q.size()) begin
          errs++;
          break;
        end
        for (int s = 0; s < 10; s++) begin
          slots[s] = q[i + s * div];
          for (int k = 1; k < div; k++)
            if (q[i + s * div + k] !== slots[s]) errs++;
        end
        if (slots[0] !== 1'b0 || slots[9] !== 1'b1) errs++;
        bytes.push_back(slots[8:1]);
        i += 10 * div;
      end else begin
        i++;
      end
    end
    return errs;
  endfunction

  task automatic compare_bytes(input string tag, input bq_t got, input bq_t exp);
    int bad;
    bad = 0;
    check({tag, "_byte_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) bad++;
    check({tag, "_byte_values"}, bad, 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [15:0] w, input bit keep, output int acc);
    data_d[d]  = w;
    valid_d[d] = 1'b1;
    acc = -1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (ready_w[d] === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) valid_d[d] = 1'b0;
        break;
      end
    end
    if (acc < 0) begin
      check("send_timeout", 0, 1);
      valid_d[d] = 1'b0;
    end
  endtask

  task automatic run_single(input int d, input logic [15:0] w, input string tag, output bq_t got);
    int  acc, wc, errs;
    lq_t seen, want;
    got = {};
    wc = word_cycles(d);
    send(d, w, 1'b0, acc);
    if (acc < 0) return;
    wait_cycles(wc + 3);
    check({tag, "_busy_c1"}, busy_log[d][acc], 1);
    check({tag, "_ready_c1"}, rdy_log[d][acc], 0);
    check({tag, "_ready_last_busy"}, rdy_log[d][acc + wc - 2], 0);
    check({tag, "_ready_after"}, rdy_log[d][acc + wc], 1);
    seen = slice(d, acc, wc + 1);
    want = line_wave(word_bytes(w), div_of(d));
    want.push_back(1'b1);
    check({tag, "_wave"}, count_diff(seen, want), 0);
    errs = decode(slice(d, acc - 1, wc + 3), div_of(d), got);
    check({tag, "_rx_errs"}, errs, 0);
    compare_bytes(tag, got, word_bytes(w));
  endtask

  task automatic run_pair(input int d, input logic [15:0] w1, input logic [15:0] w2, input string tag);
    int  a1, a2, wc, errs;
    bq_t exp_b, b2, got;
    lq_t seen, want;
    wc = word_cycles(d);
    send(d, w1, 1'b1, a1);
    if (a1 < 0) return;
    data_d[d] = w2;
    send(d, w2, 1'b0, a2);
    if (a2 < 0) return;
    wait_cycles(wc + 3);
    check({tag, "_ready_low_during"}, rdy_log[d][a1 + 1], 0);
    check({tag, "_reaccept_cycle"}, a2 - a1, wc);
    exp_b = word_bytes(w1);
    b2 = word_bytes(w2);
    foreach (b2[i]) exp_b.push_back(b2[i]);
    seen = slice(d, a1, 2 * wc);
    want = line_wave(exp_b, div_of(d));
    check({tag, "_wave"}, count_diff(seen, want), 0);
    errs = decode(slice(d, a1 - 1, 2 * wc + 3), div_of(d), got);
    check({tag, "_rx_errs"}, errs, 0);
    compare_bytes(tag, got, exp_b);
  endtask

  task automatic run_random(input int d, input int n, input string tag);
    int  a, first, prev, wc, bad_spacing, errs;
    bq_t exp_b, b, got;
    wc = word_cycles(d);
    first = -1;
    prev = -1;
    bad_spacing = 0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      wait_cycles($urandom_range(0, 3));
      send(d, w, 1'b0, a);
      if (a < 0) return;
      if (prev >= 0 && a - prev < wc) bad_spacing++;
      if (first < 0) first = a;
      prev = a;
      b = word_bytes(w);
      foreach (b[j]) exp_b.push_back(b[j]);
    end
    wait_cycles(wc + 3);
    check({tag, "_spacing"}, bad_spacing, 0);
    errs = decode(slice(d, first - 1, prev - first + wc + 3), div_of(d), got);
    check({tag, "_rx_errs"}, errs, 0);
    compare_bytes(tag, got, exp_b);
  endtask

  initial begin
    int  acc, cstart, zeros;
    bq_t got;
    lq_t want;
    for (int d = 0; d < 2; d++) begin
      data_d[d]  = '0;
      valid_d[d] = 1'b0;
    end

    // Reset state and release.
    rst_n = 1'b0;
    wait_cycles(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_tx_%0d", d), tx_w[d], 1);
      check($sformatf("reset_ready_%0d", d), ready_w[d], 0);
      check($sformatf("reset_busy_%0d", d), busy_w[d], 0);
    end
    rst_n = 1'b1;
    check("release_ready_before_edge", ready_w[0], 0);
    wait_cycles(1);
    check("release_ready_0", ready_w[0], 1);
    check("release_ready_1", ready_w[1], 1);
    check("release_busy_0", busy_w[0], 0);

    run_single(0, 16'h1234, "raw1234", got);
    run_pair(0, 16'h1234, 16'hFFFF, "holdoff");
    run_pair(0, 16'h0003, 16'h00FF, "b2b");

`ifdef OUT_TX_HEX_EN
    begin
      bq_t hex_exp;
      hex_exp = {};
      hex_exp.push_back(8'h30);
      hex_exp.push_back(8'h41);
      hex_exp.push_back(8'h33);
      hex_exp.push_back(8'h46);
      hex_exp.push_back(8'h0D);
      hex_exp.push_back(8'h0A);
      run_single(0, 16'h0A3F, "hex0a3f", got);
      compare_bytes("hex_literal", got, hex_exp);
    end
`endif

    // Reset in the middle of bit 5 of the first byte (cycles 25..28 after accept).
    want = line_wave(word_bytes(16'h1234), DIV0);
    send(0, 16'h1234, 1'b0, acc);
    if (acc >= 0) begin
      repeat (25) @(posedge clk);
      #1;
      check("midrst_busy_before", busy_w[0], 1);
      check("midrst_tx_before", tx_w[0], want[25]);
      rst_n = 1'b0;
      wait_cycles(1);
      check("midrst_tx", tx_w[0], 1);
      check("midrst_ready", ready_w[0], 0);
      check("midrst_busy", busy_w[0], 0);
      wait_cycles(2);
      rst_n = 1'b1;
      check("midrst_ready_before_edge", ready_w[0], 0);
      wait_cycles(1);
      check("midrst_ready_after", ready_w[0], 1);
      cstart = cyc;
      wait_cycles(120);
      zeros = 0;
      for (int k = cstart; k < cstart + 119; k++)
        if (tx_log[0][k] !== 1'b1) zeros++;
      check("midrst_no_residual", zeros, 0);
    end

    run_single(1, 16'h00A5, "baud2_00a5", got);
    run_random(0, 5, "rand_div4");
    run_random(1, 4, "rand_div2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/out_uart_tx.md
OUT_UART_TX -- requirements
Module: out_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 139, meaning clock cycles per UART bit (16 MHz / 115200).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, and reset is synchronous and active-low.
REQ-004 SHALL have port DATA  input  16  word from the CPU OUT port to transmit.
REQ-005 SHALL have port VALID  input  1  DATA is presented for transmission.
REQ-006 SHALL have port READY  output  1  block can accept a word this cycle.
REQ-007 SHALL have port TX  output  1  UART serial line, idle high.
REQ-008 SHALL have port BUSY  output  1  a word is being transmitted (inverse of READY outside reset).

Function
REQ-009 SHALL accept a word on a rising edge where VALID=1 and READY=1, capturing DATA into an internal register on that edge.
REQ-010 SHALL ignore DATA changes after acceptance, and ignore VALID while READY=0.
REQ-011 SHALL deassert READY and assert BUSY on the edge following acceptance.
REQ-012 SHALL drive each byte as an 8N1 frame: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-013 SHALL hold each bit on TX for exactly CLK_DIV cycles.
REQ-014 SHALL drive the start bit of the first byte on TX beginning on the edge following acceptance.
REQ-015 SHALL, in raw mode, send the high byte DATA[15:8] first, then DATA[7:0], back-to-back with no idle gap (a word takes 20*CLK_DIV cycles).
REQ-016 SHALL implement the states IDLE, START, BITS, STOP and NEXT.
REQ-017 SHALL take the transitions IDLE->START on accept, START->BITS after CLK_DIV cycles, and BITS->STOP after 8 bits.
REQ-018 SHALL take STOP->NEXT if bytes remain, otherwise STOP->IDLE, and NEXT->START in zero extra cycles (NEXT is a load state merged with the final stop cycle).
REQ-019 SHALL reassert READY on the edge at which the last stop bit completes, allowing a new accept in that same cycle (back-to-back words with no idle gap).
REQ-020 SHALL use a baud counter of width $clog2(CLK_DIV) that counts 0..CLK_DIV-1 and wraps, and a 3-bit bit counter that wraps 7->0.
REQ-021 SHALL treat CLK_DIV < 2 as an elaboration error.

Reset
REQ-022 SHALL, while RST=0, on each rising edge force the state to IDLE with TX=1, READY=0 and BUSY=0, and clear all counters.
REQ-023 SHALL set READY=1 on the first edge after RST returns high.
REQ-024 SHALL, on reset mid-frame, abandon the frame, return TX high on that edge, and retain no partial word.

Configuration
REQ-025 SHALL, with macro OUT_TX_HEX_EN defined, transmit each word as six ASCII bytes.
REQ-026 SHALL form those six bytes as four uppercase hex digits, most significant nibble first ('0'-'9','A'-'F'), followed by 0x0D then 0x0A (60*CLK_DIV cycles per word).
REQ-027 SHALL, with OUT_TX_HEX_EN undefined, operate in raw mode as in REQ-015 with no hex logic present.

Structure
REQ-028 SHALL place the state enum, ASCII constants (CR=0x0D, LF=0x0A, '0'=0x30, 'A'=0x41) and frame constants (start=0, stop=1, 8 data bits) in shared package tiny16_pkg.
REQ-029 SHALL use one sub-module, uart_tx_byte, that serializes a single byte with a load/done handshake, while out_uart_tx sequences bytes and performs hex conversion.

Verification
REQ-030 SHALL cover raw mode with CLK_DIV=4: accept DATA=0x1234 -> TX is 0 for cycles 1-4, then bits of 0x12 LSB first, stop, then 0x34 framed, and READY=1 at cycle 81.
REQ-031 SHALL cover hold-off: VALID held high with DATA changed to 0xFFFF during transmission -> only 0x1234 is sent, and 0xFFFF is accepted only when READY returns.
REQ-032 SHALL cover back-to-back: two words 0x0003 and 0x00FF presented with VALID continuous -> 4 contiguous frames with no idle TX cycles between them.
REQ-033 SHALL cover hex mode: with OUT_TX_HEX_EN defined, DATA=0x0A3F -> bytes 0x30,0x41,0x33,0x46,0x0D,0x0A decoded, 240 cycles at CLK_DIV=4.
REQ-034 SHALL cover reset mid-frame: RST=0 during bit 5 of byte 1 -> TX=1, READY=0 on the next edge, then READY=1 one edge after release, with no residual bits output.
REQ-035 SHALL cover the baud edge: CLK_DIV=2 with DATA=0x00A5 -> each bit lasts exactly 2 cycles, with frames checked by the bench UART receiver.
